l1d_data_ram_arb: RTL and testbench
===================================

# l1d_data_ram_arb

Single-port L1D data-RAM scheduler that shares the data array between the load read path and the MSHR/store write path (the decoded write request stream). It arbitrates one access per cycle, registers the RAM command, tracks read latency, and returns read data with its tag. Reads have priority, and a starvation counter bounds write wait time. It sits between the data pipe request sources and the data SRAM macro.

## Interface
- IDX_W, 6: set index width
- OFS_W, 2: offset (data-beat) width
- WAY_W, 2: way select width
- DAT_W, 128: data width; BE_W = DAT_W/8
- ID_W, 4: read tag width
- RD_LAT, 2: SRAM read latency in cycles (≥1), from `ram_en` cycle to `ram_rdat` valid
- STARVE_MAX, 4: wait cycles before a write is forced (≥1, ≤15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-high reset (asserted = 1)
- rd_req_vld  in  1  read request valid
- rd_req_rdy  out  1  read request accepted
- rd_req_index / rd_req_offset / rd_req_way  in  IDX_W / OFS_W / WAY_W  read address
- rd_req_id  in  ID_W  read tag
- wr_req_vld  in  1  write request valid
- wr_req_rdy  out  1  write request accepted
- wr_req_index / wr_req_offset / wr_req_way  in  IDX_W / OFS_W / WAY_W  write address
- wr_req_dat  in  DAT_W  write data
- wr_req_be  in  BE_W  byte enables
- ram_en  out  1  SRAM access enable
- ram_we  out  1  1 = write, 0 = read
- ram_addr  out  IDX_W+OFS_W+WAY_W  {way, index, offset}
- ram_wdat  out  DAT_W  SRAM write data
- ram_be  out  BE_W  SRAM byte enables
- ram_rdat  in  DAT_W  SRAM read data
- rd_rsp_vld  out  1  read response valid (no backpressure)
- rd_rsp_dat  out  DAT_W  read data
- rd_rsp_id  out  ID_W  tag of the returned read

## Operation
- Arbitration state has two states: RD_PRI and WR_FORCE. At most one grant per cycle.
- In RD_PRI, a valid read is granted; otherwise a valid write is granted.
- In WR_FORCE, a valid write is granted; otherwise a valid read is granted.
- `rd_req_rdy` and `wr_req_rdy` are combinational grant outputs. Handshake completes on vld&&rdy.
- Requesters hold vld and payload stable until rdy.
- Starvation counter (4 bits):
  - It clears on any write grant or when `wr_req_vld` is 0.
  - Otherwise it increments each cycle that `wr_req_vld` is 1 and the write is not granted, saturating at STARVE_MAX.
- Transitions:
  - RD_PRI → WR_FORCE when the counter equals STARVE_MAX.
  - WR_FORCE → RD_PRI on a write grant, or when `wr_req_vld` is 0.
- Grants register into the RAM command: `ram_en`=1, `ram_we`=(write granted), `ram_addr`/`ram_wdat`/`ram_be` from the granted payload. On a read or idle cycle, `ram_wdat`/`ram_be` are 0.
- Read tracking uses an RD_LAT-deep shift register of {vld, id}, loaded from the registered read command. `rd_rsp_vld`/`rd_rsp_id` come from the tail. `rd_rsp_dat` = `ram_rdat` when `rd_rsp_vld`, else 0.
- Ordering: accesses reach the SRAM in grant order. A read issued the cycle after a write to the same address returns the new data; the SRAM is write-then-read ordered across cycles.

## Timing
- Grant at cycle t → `ram_en` at t+1 → `rd_rsp_vld` at t+1+RD_LAT.
- Throughput is 1 access per cycle. Reads and writes may interleave back-to-back.
- Worst-case write wait under continuous reads is STARVE_MAX+1 cycles (with the starvation feature compiled in).
- Reset values: all outputs 0, state RD_PRI, counter 0, shift register empty.
- Reset asserted mid-operation: in-flight reads are dropped with no response; the RAM command is deasserted immediately (asynchronous).
- Simultaneous rd and wr valid with counter < STARVE_MAX in RD_PRI: the read wins and the counter increments.

## Configuration
- `L1D_DATA_ARB_STARVE_EN`:
  - Defined: starvation counter and WR_FORCE state as above.
  - Undefined: the state is fixed at RD_PRI, there is no counter, and arbitration is strict read priority (writes can starve indefinitely).

## Test plan
- Single read: rd idx=5, ofs=1, way=2, id=3 at cycle 0 → `ram_en`=1, `ram_we`=0, `ram_addr`={2,5,1} at cycle 1. With `ram_rdat`=0xA5..A5 → `rd_rsp_vld`=1, id=3, data 0xA5..A5 at cycle 1+RD_LAT.
- Single write: wr idx=7, be=0xFFFF, dat=0x1234 → next cycle `ram_we`=1, `ram_be`=0xFFFF, `ram_wdat`=0x1234, and no `rd_rsp_vld` afterwards.
- Starvation: continuous reads plus a write held valid from cycle 0, STARVE_MAX=4 → write granted at cycle 5 and reads resume at cycle 6. With the macro undefined, the write is never granted while reads continue.
- Back-to-back reads with ids 0..7 → 8 consecutive responses in order, ids 0..7, with no gaps.
- Write-then-read to the same address → the read returns the written data.
- Reset asserted with 2 reads in flight → no `rd_rsp_vld` after reset. The first request after deassertion is granted in RD_PRI with the counter at 0.

Source files
------------

// File: rtl/l1d_data_ram_arb_if.sv
// Bus bundle for the L1D data-RAM scheduler: read/write request channels,
// the SRAM command/return port and the read response channel.
interface l1d_data_ram_arb_if #(
  parameter int IDX_W = 6,
  parameter int OFS_W = 2,
  parameter int WAY_W = 2,
  parameter int DAT_W = 128,
  parameter int ID_W  = 4
) ();
  localparam int BE_W  = DAT_W / 8;
  localparam int ADR_W = IDX_W + OFS_W + WAY_W;

  logic             rd_req_vld;
  logic             rd_req_rdy;
  logic [IDX_W-1:0] rd_req_index;
  logic [OFS_W-1:0] rd_req_offset;
  logic [WAY_W-1:0] rd_req_way;
  logic [ID_W-1:0]  rd_req_id;

  logic             wr_req_vld;
  logic             wr_req_rdy;
  logic [IDX_W-1:0] wr_req_index;
  logic [OFS_W-1:0] wr_req_offset;
  logic [WAY_W-1:0] wr_req_way;
  logic [DAT_W-1:0] wr_req_dat;
  logic [BE_W-1:0]  wr_req_be;

  logic             ram_en;
  logic             ram_we;
  logic [ADR_W-1:0] ram_addr;
  logic [DAT_W-1:0] ram_wdat;
  logic [BE_W-1:0]  ram_be;
  logic [DAT_W-1:0] ram_rdat;

  logic             rd_rsp_vld;
  logic [DAT_W-1:0] rd_rsp_dat;
  logic [ID_W-1:0]  rd_rsp_id;

  // Requesters plus SRAM macro side.
  modport master (
    output rd_req_vld, rd_req_index,
    output rd_req_offset, rd_req_way,
    output rd_req_id,
    input  rd_req_rdy,
    output wr_req_vld, wr_req_index,
    output wr_req_offset, wr_req_way,
    output wr_req_dat, wr_req_be,
    input  wr_req_rdy,
    input  ram_en, ram_we, ram_addr,
    input  ram_wdat, ram_be,
    output ram_rdat,
    input  rd_rsp_vld, rd_rsp_dat,
    input  rd_rsp_id
  );

  // Scheduler side.
  modport slave (
    input  rd_req_vld, rd_req_index,
    input  rd_req_offset, rd_req_way,
    input  rd_req_id,
    output rd_req_rdy,
    input  wr_req_vld, wr_req_index,
    input  wr_req_offset, wr_req_way,
    input  wr_req_dat, wr_req_be,
    output wr_req_rdy,
    output ram_en, ram_we, ram_addr,
    output ram_wdat, ram_be,
    input  ram_rdat,
    output rd_rsp_vld, rd_rsp_dat,
    output rd_rsp_id
  );
endinterface

// File: rtl/l1d_data_ram_arb.sv
// L1D data-RAM scheduler: one SRAM access per cycle, reads first,
// registered RAM command, RD_LAT-deep read tag pipe for responses.
// Ports: clk, rst_n (async, active-high), bus (l1d_data_ram_arb_if.slave).
// Option: L1D_DATA_ARB_STARVE_EN adds the write starvation counter and
// the WR_FORCE state; without it arbitration is strict read priority.
module l1d_data_ram_arb #(
  parameter int IDX_W      = 6,
  parameter int OFS_W      = 2,
  parameter int WAY_W      = 2,
  parameter int DAT_W      = 128,
  parameter int ID_W       = 4,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  l1d_data_ram_arb_if.slave bus
);
  localparam int BE_W  = DAT_W / 8;
  localparam int ADR_W = IDX_W + OFS_W + WAY_W;

  if (RD_LAT < 1) begin : g_lat_chk
    $error("RD_LAT must be >= 1");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_stv_chk
    $error("STARVE_MAX must be 1..15");
  end

  logic gnt_rd;
  logic gnt_wr;

`ifdef L1D_DATA_ARB_STARVE_EN
  typedef enum logic {
    RD_PRI   = 1'b0,
    WR_FORCE = 1'b1
  } st_e;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  st_e        st_q;
  st_e        st_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      st_q  <= RD_PRI;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      RD_PRI: begin
        if (cnt_q == CNT_MAX)
          st_d = WR_FORCE;
      end
      WR_FORCE: begin
        if (gnt_wr || !bus.wr_req_vld)
          st_d = RD_PRI;
      end
      default: st_d = RD_PRI;
    endcase
    // Counts cycles a valid write was passed over.
    cnt_d = cnt_q;
    if (gnt_wr || !bus.wr_req_vld)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + 4'd1;
  end

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (!rst_n) begin
      unique case (st_q)
        RD_PRI: begin
          gnt_rd = bus.rd_req_vld;
          gnt_wr = bus.wr_req_vld &&
                   !bus.rd_req_vld;
        end
        WR_FORCE: begin
          gnt_wr = bus.wr_req_vld;
          gnt_rd = bus.rd_req_vld &&
                   !bus.wr_req_vld;
        end
        default: ;
      endcase
    end
  end
`else
  always_comb begin
    gnt_rd = bus.rd_req_vld && !rst_n;
    gnt_wr = bus.wr_req_vld &&
             !bus.rd_req_vld && !rst_n;
  end
`endif

  assign bus.rd_req_rdy = gnt_rd;
  assign bus.wr_req_rdy = gnt_wr;

  logic             en_q;
  logic             we_q;
  logic [ADR_W-1:0] addr_q;
  logic [DAT_W-1:0] wdat_q;
  logic [BE_W-1:0]  be_q;
  logic [ID_W-1:0]  id_q;

  logic [ADR_W-1:0] rd_addr;
  logic [ADR_W-1:0] wr_addr;

  assign rd_addr = {bus.rd_req_way,
                    bus.rd_req_index,
                    bus.rd_req_offset};
  assign wr_addr = {bus.wr_req_way,
                    bus.wr_req_index,
                    bus.wr_req_offset};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      be_q   <= '0;
      id_q   <= '0;
    end else begin
      en_q   <= gnt_rd || gnt_wr;
      we_q   <= gnt_wr;
      addr_q <= gnt_wr ? wr_addr :
                gnt_rd ? rd_addr : '0;
      wdat_q <= gnt_wr ? bus.wr_req_dat : '0;
      be_q   <= gnt_wr ? bus.wr_req_be : '0;
      id_q   <= gnt_rd ? bus.rd_req_id : '0;
    end
  end

  assign bus.ram_en   = en_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_wdat = wdat_q;
  assign bus.ram_be   = be_q;

  // Stage 0 follows the issued command; the tail lines up with ram_rdat.
  logic [RD_LAT-1:0] pv_q;
  logic [ID_W-1:0]   pid_q [RD_LAT];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i]  <= 1'b0;
        pid_q[i] <= '0;
      end
    end else begin
      pv_q[0]  <= en_q && !we_q;
      pid_q[0] <= id_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  assign bus.rd_rsp_vld = pv_q[RD_LAT-1];
  assign bus.rd_rsp_id  = pid_q[RD_LAT-1];
  assign bus.rd_rsp_dat = pv_q[RD_LAT-1] ?
                          bus.ram_rdat : '0;
endmodule

// File: tb/tb_l1d_data_ram_arb.sv
// Directed bench for l1d_data_ram_arb with an SRAM model and a
// read-response scoreboard.
module tb_l1d_data_ram_arb;
  localparam int IDX_W = 6;
  localparam int OFS_W = 2;
  localparam int WAY_W = 2;
  localparam int DAT_W = 128;
  localparam int ID_W  = 4;
  localparam int RD_LAT = 2;
  localparam int STARVE_MAX = 4;
  localparam int BE_W  = DAT_W / 8;
  localparam int ADR_W = IDX_W + OFS_W + WAY_W;
`ifdef L1D_DATA_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  l1d_data_ram_arb_if #(
    .IDX_W(IDX_W), .OFS_W(OFS_W), .WAY_W(WAY_W),
    .DAT_W(DAT_W), .ID_W(ID_W)
  ) bus ();

  l1d_data_ram_arb #(
    .IDX_W(IDX_W), .OFS_W(OFS_W), .WAY_W(WAY_W),
    .DAT_W(DAT_W), .ID_W(ID_W),
    .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [DAT_W-1:0] obs,
                     input logic [DAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DAT_W-1:0] merge(
    input logic [DAT_W-1:0] old,
    input logic [DAT_W-1:0] dat,
    input logic [BE_W-1:0]  be);
    logic [DAT_W-1:0] m;
    m = old;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) m[8*b +: 8] = dat[8*b +: 8];
    return m;
  endfunction

  function automatic logic [DAT_W-1:0] pat(input int i);
    return {4{32'(i) * 32'h9E37_79B9}};
  endfunction

  // SRAM model
  logic [DAT_W-1:0] mem [1 << ADR_W];
  logic [DAT_W-1:0] rpipe [RD_LAT];
  assign bus.ram_rdat = rpipe[RD_LAT-1];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we)
        mem[bus.ram_addr] <= merge(mem[bus.ram_addr],
                                   bus.ram_wdat, bus.ram_be);
      else
        rpipe[0] <= mem[bus.ram_addr];
    end
    for (int i = 1; i < RD_LAT; i++)
      rpipe[i] <= rpipe[i-1];
  end

  // Scoreboard: expected data captured from a shadow memory at grant.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [DAT_W-1:0] dat;
  } exp_t;

  exp_t sb[$];
  logic [DAT_W-1:0] shadow [1 << ADR_W];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      if (bus.rd_rsp_vld) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", bus.rd_rsp_vld, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp_id", bus.rd_rsp_id, e.id);
          chk("sb_rsp_dat", bus.rd_rsp_dat, e.dat);
        end
      end
      if (bus.wr_req_vld && bus.wr_req_rdy)
        shadow[{bus.wr_req_way, bus.wr_req_index,
                bus.wr_req_offset}] =
          merge(shadow[{bus.wr_req_way, bus.wr_req_index,
                        bus.wr_req_offset}],
                bus.wr_req_dat, bus.wr_req_be);
      if (bus.rd_req_vld && bus.rd_req_rdy) begin
        e.id  = bus.rd_req_id;
        e.dat = shadow[{bus.rd_req_way, bus.rd_req_index,
                        bus.rd_req_offset}];
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_drive(input logic v, input int idx,
                          input int ofs, input int way,
                          input int id);
    bus.rd_req_vld    = v;
    bus.rd_req_index  = IDX_W'(idx);
    bus.rd_req_offset = OFS_W'(ofs);
    bus.rd_req_way    = WAY_W'(way);
    bus.rd_req_id     = ID_W'(id);
  endtask

  task automatic wr_drive(input logic v, input int idx,
                          input int ofs, input int way,
                          input logic [DAT_W-1:0] dat,
                          input logic [BE_W-1:0] be);
    bus.wr_req_vld    = v;
    bus.wr_req_index  = IDX_W'(idx);
    bus.wr_req_offset = OFS_W'(ofs);
    bus.wr_req_way    = WAY_W'(way);
    bus.wr_req_dat    = dat;
    bus.wr_req_be     = be;
  endtask

  // Reads every cycle with a write held valid from cycle 0.
  task automatic starve_run(input int id0);
    int id;
    logic g_rd;
    logic g_wr;
    logic exp_w;
    id = id0;
    wr_drive(1'b1, 9, 3, 1, pat(777), 16'h0F0F);
    for (int c = 0; c < 10; c++) begin
      rd_drive(1'b1, id % 64, 0, 3, id);
      #1;
      exp_w = STARVE_EN && (c == STARVE_MAX + 1);
      chk($sformatf("starve_wr_rdy_c%0d", c),
          bus.wr_req_rdy, exp_w);
      chk($sformatf("starve_rd_rdy_c%0d", c),
          bus.rd_req_rdy, !exp_w);
      g_rd = bus.rd_req_rdy;
      g_wr = bus.wr_req_rdy;
      tick();
      if (g_rd) id++;
      if (g_wr) bus.wr_req_vld = 1'b0;
    end
    rd_drive(1'b0, 0, 0, 0, 0);
    #1;
    if (bus.wr_req_vld)
      chk("starve_wr_late", bus.wr_req_rdy, 1);
    tick();
    bus.wr_req_vld = 1'b0;
  endtask

  localparam logic [DAT_W-1:0] A5 = {16{8'hA5}};
  localparam logic [DAT_W-1:0] D1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
  localparam logic [DAT_W-1:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  initial begin
    logic exp_v;
    for (int i = 0; i < (1 << ADR_W); i++) begin
      mem[i]    = pat(i);
      shadow[i] = pat(i);
    end
    for (int i = 0; i < RD_LAT; i++) rpipe[i] = '0;
    mem[{2'd2, 6'd5, 2'd1}]    = A5;
    shadow[{2'd2, 6'd5, 2'd1}] = A5;
    rd_drive(1'b1, 0, 0, 0, 0);
    wr_drive(1'b0, 0, 0, 0, '0, '0);

    // Reset state (read valid held to show grants stay low)
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_rsp_vld", bus.rd_rsp_vld, 0);
    chk("rst_rd_rdy", bus.rd_req_rdy, 0);
    bus.rd_req_vld = 1'b0;
    rst_n = 1'b0;
    tick();

    // Single read
    rd_drive(1'b1, 5, 1, 2, 3);
    #1;
    chk("rd1_rdy", bus.rd_req_rdy, 1);
    tick();
    rd_drive(1'b0, 0, 0, 0, 0);
    #1;
    chk("rd1_ram_en", bus.ram_en, 1);
    chk("rd1_ram_we", bus.ram_we, 0);
    chk("rd1_ram_addr", bus.ram_addr, 10'b10_000101_01);
    chk("rd1_ram_wdat", bus.ram_wdat, 0);
    chk("rd1_ram_be", bus.ram_be, 0);
    repeat (RD_LAT - 1) tick();
    #1;
    chk("rd1_rsp_early", bus.rd_rsp_vld, 0);
    tick();
    #1;
    chk("rd1_rsp_vld", bus.rd_rsp_vld, 1);
    chk("rd1_rsp_id", bus.rd_rsp_id, 3);
    chk("rd1_rsp_dat", bus.rd_rsp_dat, A5);
    tick();

    // Single write
    wr_drive(1'b1, 7, 0, 0, 128'h1234, 16'hFFFF);
    #1;
    chk("wr1_rdy", bus.wr_req_rdy, 1);
    chk("wr1_rd_rdy", bus.rd_req_rdy, 0);
    tick();
    bus.wr_req_vld = 1'b0;
    #1;
    chk("wr1_ram_en", bus.ram_en, 1);
    chk("wr1_ram_we", bus.ram_we, 1);
    chk("wr1_ram_addr", bus.ram_addr, 10'd28);
    chk("wr1_ram_be", bus.ram_be, 16'hFFFF);
    chk("wr1_ram_wdat", bus.ram_wdat, 128'h1234);
    for (int i = 0; i < RD_LAT + 2; i++) begin
      tick();
      chk("wr1_no_rsp", bus.rd_rsp_vld, 0);
    end

    // Starvation
    starve_run(0);
    repeat (RD_LAT + 2) tick();

    // Back-to-back reads, ids 0..7
    for (int i = 0; i <= 8 + RD_LAT; i++) begin
      rd_drive(i < 8, i + 16, i % 4, 1, i);
      #1;
      if (i < 8) chk("b2b_rdy", bus.rd_req_rdy, 1);
      exp_v = (i >= 1 + RD_LAT);
      chk($sformatf("b2b_rsp_vld_%0d", i),
          bus.rd_rsp_vld, exp_v);
      if (exp_v)
        chk("b2b_rsp_id", bus.rd_rsp_id, i - 1 - RD_LAT);
      tick();
    end
    rd_drive(1'b0, 0, 0, 0, 0);
    #1;
    chk("b2b_tail", bus.rd_rsp_vld, 0);
    tick();

    // Write then read, same address
    wr_drive(1'b1, 33, 2, 1, D1, 16'hFFFF);
    #1;
    chk("wtr_wr_rdy", bus.wr_req_rdy, 1);
    tick();
    bus.wr_req_vld = 1'b0;
    rd_drive(1'b1, 33, 2, 1, 9);
    #1;
    chk("wtr_rd_rdy", bus.rd_req_rdy, 1);
    tick();
    rd_drive(1'b0, 0, 0, 0, 0);
    repeat (RD_LAT) tick();
    #1;
    chk("wtr_rsp_vld", bus.rd_rsp_vld, 1);
    chk("wtr_rsp_dat", bus.rd_rsp_dat, D1);
    tick();
    // Partial byte-enable write, read checked by the scoreboard
    wr_drive(1'b1, 33, 2, 1, D2, 16'h00F0);
    tick();
    bus.wr_req_vld = 1'b0;
    rd_drive(1'b1, 33, 2, 1, 10);
    tick();
    rd_drive(1'b0, 0, 0, 0, 0);
    repeat (RD_LAT + 2) tick();

    // Reset with two reads in flight and a pending write
    wr_drive(1'b1, 50, 0, 0, D2, 16'hFFFF);
    rd_drive(1'b1, 40, 0, 0, 1);
    tick();
    rd_drive(1'b1, 41, 0, 0, 2);
    tick();
    rd_drive(1'b0, 0, 0, 0, 0);
    bus.wr_req_vld = 1'b0;
    chk("mrst_ram_en_pre", bus.ram_en, 1);
    rst_n = 1'b1;
    #1;
    chk("mrst_ram_en", bus.ram_en, 0);
    chk("mrst_rsp_vld", bus.rd_rsp_vld, 0);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      tick();
      chk("mrst_no_rsp", bus.rd_rsp_vld, 0);
    end
    starve_run(4);
    repeat (RD_LAT + 3) tick();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
